// File: rtl/sw_seq_fsm.sv
// -----------------------------------------------------------------------------
// sw_seq_fsm
// -----------------------------------------------------------------------------
// Switch-driven sequencer: IDLE -> ST1..ST4 with one LED pattern per state.
// The raw board switches pass through a 2-flop synchroniser and a stability
// filter before they reach the FSM. Each non-IDLE state has an inactivity
// timeout that returns to IDLE. An enable freezes the FSM and the timeout.
// Two registered status pulses report a state change (chg) and a timeout
// return (tmo).
//
// Parameters
//   SW_W        switch / LED width (>= 2)
//   STABLE_CYC  consecutive equal synced samples before sw_f updates (>= 1)
//   TIMEOUT_CYC cycles without a transition in ST1..ST4 before returning
//               to IDLE (0 disables the timeout)
//   CODE1..4    switch codes selecting ST1..ST4 (distinct, nonzero)
//
// Ports
//   clk    in   1     system clock, rising edge
//   rst    in   1     asynchronous reset, active low
//   en     in   1     1 = FSM and timeout advance, 0 = both frozen
//   sw     in   SW_W  raw asynchronous switch inputs
//   led    out  SW_W  LED pattern: IDLE = 0, STn = CODEn
//   state  out  3     IDLE=0, ST1=1, ST2=2, ST3=3, ST4=4
//   chg    out  1     one-cycle pulse on the edge where state changes
//   tmo    out  1     one-cycle pulse on the edge of a timeout return
//
// Build option
//   SW_FSM_MEALY_EN  defined: led is combinational from (state, sw_f, en)
//                    and shows the code of the state about to be entered,
//                    one cycle ahead of the state register.
//                    undefined (default): led is registered alongside the
//                    state and depends only on the state.
// -----------------------------------------------------------------------------
module sw_seq_fsm #(
    parameter int               SW_W        = 3,
    parameter int               STABLE_CYC  = 4,
    parameter int               TIMEOUT_CYC = 1000,
    parameter logic [SW_W-1:0]  CODE1       = SW_W'(3'd1),
    parameter logic [SW_W-1:0]  CODE2       = SW_W'(3'd2),
    parameter logic [SW_W-1:0]  CODE3       = SW_W'(3'd4),
    parameter logic [SW_W-1:0]  CODE4       = {SW_W{1'b1}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [SW_W-1:0] sw,
    output logic [SW_W-1:0] led,
    output logic [2:0]      state,
    output logic            chg,
    output logic            tmo
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ST1  = 3'd1,
        S_ST2  = 3'd2,
        S_ST3  = 3'd3,
        S_ST4  = 3'd4
    } state_t;

    // Stability counter saturates at STABLE_CYC, so it needs one extra code.
    localparam int               STB_W    = (STABLE_CYC < 1) ? 1 : $clog2(STABLE_CYC + 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYC);

    // Timeout counter only ever reaches TIMEOUT_CYC-1 before it clears.
    localparam int               TMO_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT_CYC < 1) ? {TMO_W{1'b0}} : TMO_W'(TIMEOUT_CYC - 1);
    localparam logic             TMO_ON   = (TIMEOUT_CYC > 0) ? 1'b1 : 1'b0;

    // Legal transition table; any code not listed keeps the current state.
    // Encodings outside IDLE..ST4 fall back to IDLE.
    function automatic state_t next_of(input state_t s, input logic [SW_W-1:0] f);
        state_t n;
        n = s;
        case (s)
            S_IDLE: begin
                if (f == CODE1)      n = S_ST1;
                else if (f == CODE2) n = S_ST2;
                else                 n = S_IDLE;
            end
            S_ST1: begin
                if (f == CODE2) n = S_ST2;
                else            n = S_ST1;
            end
            S_ST2: begin
                if (f == CODE3) n = S_ST3;
                else            n = S_ST2;
            end
            S_ST3: begin
                if (f == {SW_W{1'b0}}) n = S_IDLE;
                else if (f == CODE4)   n = S_ST4;
                else if (f == CODE1)   n = S_ST1;
                else                   n = S_ST3;
            end
            S_ST4: begin
                if (f == CODE3) n = S_ST3;
                else            n = S_ST4;
            end
            default: n = S_IDLE;
        endcase
        return n;
    endfunction

    // LED pattern shown for a given state.
    function automatic logic [SW_W-1:0] code_of(input state_t s);
        logic [SW_W-1:0] c;
        case (s)
            S_IDLE:  c = {SW_W{1'b0}};
            S_ST1:   c = CODE1;
            S_ST2:   c = CODE2;
            S_ST3:   c = CODE3;
            S_ST4:   c = CODE4;
            default: c = {SW_W{1'b0}};
        endcase
        return c;
    endfunction

    // Input conditioning state.
    logic [SW_W-1:0]  r_sync1;
    logic [SW_W-1:0]  r_sync2;
    logic [SW_W-1:0]  r_last;
    logic [STB_W-1:0] r_stb_cnt;
    logic [SW_W-1:0]  r_sw_f;
    logic [STB_W-1:0] w_stb_nxt;

    // FSM state.
    state_t           r_state;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_chg;
    logic             r_tmo;
`ifdef SW_FSM_MEALY_EN
`else
    logic [SW_W-1:0]  r_led;
`endif

    state_t           w_rule_nxt;
    logic             w_legal;
    logic             w_to_hit;
    state_t           w_next;
    logic             w_tmo_fire;

    // Run length of the current synced value; a new value starts a run of one.
    always_comb begin
        w_stb_nxt = r_stb_cnt;
        if (r_sync2 != r_last) begin
            w_stb_nxt = STB_W'(1);
        end else if (r_stb_cnt < STB_LAST) begin
            w_stb_nxt = r_stb_cnt + STB_W'(1);
        end else begin
            w_stb_nxt = r_stb_cnt;
        end
    end

    // Synchroniser and stability filter; both run regardless of en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= {SW_W{1'b0}};
            r_sync2   <= {SW_W{1'b0}};
            r_last    <= {SW_W{1'b0}};
            r_stb_cnt <= {STB_W{1'b0}};
            r_sw_f    <= {SW_W{1'b0}};
        end else begin
            r_sync1   <= sw;
            r_sync2   <= r_sync1;
            r_last    <= r_sync2;
            r_stb_cnt <= w_stb_nxt;
            if (w_stb_nxt >= STB_LAST) begin
                r_sw_f <= r_sync2;
            end else begin
                r_sw_f <= r_sw_f;
            end
        end
    end

    // Next-state selection: a legal transition takes priority over the
    // timeout, and en=0 freezes everything.
    always_comb begin
        w_rule_nxt = next_of(r_state, r_sw_f);
        w_legal    = (w_rule_nxt != r_state);
        w_to_hit   = TMO_ON && (r_state != S_IDLE) && (r_tmo_cnt == TMO_LAST) && !w_legal;
        w_next     = r_state;
        w_tmo_fire = 1'b0;
        if (!en) begin
            w_next     = r_state;
            w_tmo_fire = 1'b0;
        end else if (w_to_hit) begin
            w_next     = S_IDLE;
            w_tmo_fire = 1'b1;
        end else begin
            w_next     = w_rule_nxt;
            w_tmo_fire = 1'b0;
        end
    end

    // FSM, inactivity counter and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_tmo_cnt <= {TMO_W{1'b0}};
            r_chg     <= 1'b0;
            r_tmo     <= 1'b0;
`ifdef SW_FSM_MEALY_EN
`else
            r_led     <= {SW_W{1'b0}};
`endif
        end else begin
            r_state <= w_next;
            r_chg   <= (w_next != r_state);
            r_tmo   <= w_tmo_fire;
            // The counter measures time spent in the current non-IDLE state.
            if ((w_next != r_state) || (r_state == S_IDLE)) begin
                r_tmo_cnt <= {TMO_W{1'b0}};
            end else if (en && TMO_ON) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end else begin
                r_tmo_cnt <= r_tmo_cnt;
            end
`ifdef SW_FSM_MEALY_EN
`else
            r_led <= code_of(w_next);
`endif
        end
    end

    assign state = r_state;
    assign chg   = r_chg;
    assign tmo   = r_tmo;

`ifdef SW_FSM_MEALY_EN
    // Lead the state register by showing the pattern of the upcoming state.
    assign led = code_of(w_next);
`else
    assign led = r_led;
`endif

endmodule

// File: tb/tb_sw_seq_fsm.sv
module tb_sw_seq_fsm;

    localparam int STB = 4;
    localparam int TMO = 16;
`ifdef SW_FSM_MEALY_EN
    localparam int LEAD = 1;
`else
    localparam int LEAD = 0;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] sw;
    logic [2:0] led;
    logic [2:0] state;
    logic       chg;
    logic       tmo;

    int total;
    int bad;
    int cyc_n;

    // Reference model: state number, enabled cycles spent in it, filtered switch
    int  m_state;
    int  m_age;
    int  m_swf;
    bit  m_chg;
    bit  m_tmo;
    int  rawq[$];

    int led_of[5]  = '{0, 1, 2, 4, 7};
    int r_from[8]  = '{0, 0, 1, 2, 3, 3, 3, 4};
    int r_code[8]  = '{1, 2, 2, 4, 0, 7, 1, 4};
    int r_to[8]    = '{1, 2, 2, 3, 0, 4, 1, 3};

    sw_seq_fsm #(
        .SW_W(3),
        .STABLE_CYC(STB),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .sw(sw),
        .led(led),
        .state(state),
        .chg(chg),
        .tmo(tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int model_next(input int s, input int f, input bit e, input int age, output bit fired);
        fired = 1'b0;
        if (!e) return s;
        for (int r = 0; r < 8; r++) begin
            if (r_from[r] == s && r_code[r] == f) return r_to[r];
        end
        if (s != 0 && age + 1 == TMO) begin
            fired = 1'b1;
            return 0;
        end
        return s;
    endfunction

    function automatic int exp_led(input bit e);
        bit d;
        int nx;
        nx = model_next(m_state, m_swf, e, m_age, d);
        return (LEAD == 1) ? led_of[nx] : led_of[m_state];
    endfunction

    task automatic model_reset();
        m_state = 0; m_age = 0; m_swf = 0; m_chg = 1'b0; m_tmo = 1'b0;
        rawq.delete();
        for (int i = 0; i < STB + 2; i++) rawq.push_back(0);
    endtask

    // One clock edge of the model: raw samples two edges old form the filter window.
    task automatic model_edge(input int sw_v, input bit en_v);
        bit f;
        int nx;
        bit same;
        int sz;
        nx = model_next(m_state, m_swf, en_v, m_age, f);
        m_chg = (nx != m_state);
        m_tmo = f;
        if (en_v) begin
            if (nx != m_state || m_state == 0) m_age = 0;
            else m_age = m_age + 1;
        end
        m_state = nx;
        sz = rawq.size();
        same = 1'b1;
        for (int i = sz - 1 - STB; i <= sz - 2; i++) begin
            if (rawq[i] != rawq[sz - 1 - STB]) same = 1'b0;
        end
        if (same) m_swf = rawq[sz - 1 - STB];
        rawq.push_back(sw_v);
        void'(rawq.pop_front());
    endtask

    task automatic cyc(input int sw_v, input bit en_v);
        sw = 3'(sw_v);
        en = en_v;
        @(posedge clk);
        model_edge(sw_v, en_v);
        cyc_n++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; sw = 3'b111; en = 1'b1;
        model_reset();
        #2;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
        total++; if (led !== 3'd0) begin bad++; $display("FAIL rst_led got=%0d want=0", led); end
        total++; if (chg !== 1'b0) begin bad++; $display("FAIL rst_chg got=%0b want=0", chg); end
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL rst_tmo got=%0b want=0", tmo); end
        @(posedge clk); @(posedge clk); #1;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_hold_state got=%0d want=0", state); end
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc(0, 1'b1);
            total++; if (state !== 3'(m_state)) begin bad++; $display("FAIL idle_state cyc=%0d got=%0d want=%0d", cyc_n, state, m_state); end
            total++; if (led !== 3'(exp_led(en))) begin bad++; $display("FAIL idle_led cyc=%0d got=%0d want=%0d", cyc_n, led, exp_led(en)); end
            total++; if (chg !== m_chg) begin bad++; $display("FAIL idle_chg cyc=%0d got=%0b want=%0b", cyc_n, chg, m_chg); end
        end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL idle_end got=%0d want=0", state); end
    endtask

    task automatic test_walk();
        int codes[6]  = '{1, 2, 4, 7, 4, 0};
        int exp_st[6] = '{1, 2, 3, 4, 3, 0};
        int exp_ld[6] = '{1, 2, 4, 7, 4, 0};
        for (int i = 0; i < 6; i++) begin
            int st_edge;
            int ld_edge;
            int nchg;
            logic [2:0] st0;
            logic [2:0] ld0;
            st_edge = -1; ld_edge = -1; nchg = 0; st0 = state; ld0 = led;
            for (int k = 1; k <= 10; k++) begin
                cyc(codes[i], 1'b1);
                total++; if (state !== 3'(m_state)) begin bad++; $display("FAIL walk_state cyc=%0d got=%0d want=%0d", cyc_n, state, m_state); end
                total++; if (led !== 3'(exp_led(en))) begin bad++; $display("FAIL walk_led cyc=%0d got=%0d want=%0d", cyc_n, led, exp_led(en)); end
                total++; if (chg !== m_chg) begin bad++; $display("FAIL walk_chg cyc=%0d got=%0b want=%0b", cyc_n, chg, m_chg); end
                total++; if (tmo !== m_tmo) begin bad++; $display("FAIL walk_tmo cyc=%0d got=%0b want=%0b", cyc_n, tmo, m_tmo); end
                if (chg === 1'b1) nchg++;
                if (st_edge < 0 && state !== st0) st_edge = k;
                if (ld_edge < 0 && led !== ld0) ld_edge = k;
            end
            total++; if (st_edge != 7) begin bad++; $display("FAIL walk_latency step=%0d got=%0d want=7", i, st_edge); end
            total++; if (ld_edge != 7 - LEAD) begin bad++; $display("FAIL walk_led_edge step=%0d got=%0d want=%0d", i, ld_edge, 7 - LEAD); end
            total++; if (nchg != 1) begin bad++; $display("FAIL walk_chg_count step=%0d got=%0d want=1", i, nchg); end
            total++; if (state !== 3'(exp_st[i])) begin bad++; $display("FAIL walk_final_state step=%0d got=%0d want=%0d", i, state, exp_st[i]); end
            total++; if (led !== 3'(exp_ld[i])) begin bad++; $display("FAIL walk_final_led step=%0d got=%0d want=%0d", i, led, exp_ld[i]); end
        end
    endtask

    task automatic test_debounce();
        int nchg;
        int n;
        nchg = 0;
        for (int k = 0; k < 15; k++) begin
            cyc((k < 3) ? 1 : 0, 1'b1);
            total++; if (state !== 3'(m_state)) begin bad++; $display("FAIL glitch_state cyc=%0d got=%0d want=%0d", cyc_n, state, m_state); end
            total++; if (led !== 3'(exp_led(en))) begin bad++; $display("FAIL glitch_led cyc=%0d got=%0d want=%0d", cyc_n, led, exp_led(en)); end
            if (chg === 1'b1) nchg++;
        end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL glitch_end_state got=%0d want=0", state); end
        total++; if (nchg != 0) begin bad++; $display("FAIL glitch_chg_count got=%0d want=0", nchg); end
        n = 0;
        while (state !== 3'd1 && n < 20) begin
            cyc(1, 1'b1);
            n++;
            total++; if (state !== 3'(m_state)) begin bad++; $display("FAIL deb_state cyc=%0d got=%0d want=%0d", cyc_n, state, m_state); end
        end
        total++; if (n != 7) begin bad++; $display("FAIL deb_latency got=%0d want=7", n); end
    endtask

    task automatic test_timeout();
        int n;
        logic [2:0] led_prev;
        n = 0;
        while (state !== 3'd2 && n < 20) begin
            cyc(2, 1'b1);
            n++;
        end
        total++; if (state !== 3'd2) begin bad++; $display("FAIL to_enter_st2 got=%0d want=2", state); end
        n = 0;
        led_prev = led;
        while (state === 3'd2 && n < 40) begin
            led_prev = led;
            cyc(2, 1'b1);
            n++;
            total++; if (state !== 3'(m_state)) begin bad++; $display("FAIL to_state cyc=%0d got=%0d want=%0d", cyc_n, state, m_state); end
            total++; if (led !== 3'(exp_led(en))) begin bad++; $display("FAIL to_led cyc=%0d got=%0d want=%0d", cyc_n, led, exp_led(en)); end
            total++; if (tmo !== m_tmo) begin bad++; $display("FAIL to_tmo cyc=%0d got=%0b want=%0b", cyc_n, tmo, m_tmo); end
        end
        total++; if (n != TMO) begin bad++; $display("FAIL to_cycles got=%0d want=%0d", n, TMO); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL to_idle got=%0d want=0", state); end
        total++; if (tmo !== 1'b1) begin bad++; $display("FAIL to_pulse got=%0b want=1", tmo); end
        total++; if (chg !== 1'b1) begin bad++; $display("FAIL to_chg got=%0b want=1", chg); end
        if (LEAD == 1) begin
            total++; if (led_prev !== 3'd0) begin bad++; $display("FAIL to_led_lead got=%0d want=0", led_prev); end
        end else begin
            total++; if (led !== 3'd0) begin bad++; $display("FAIL to_led_idle got=%0d want=0", led); end
        end
        // sw_f still holds CODE2, so IDLE re-enters ST2 on the next edge
        cyc(2, 1'b1);
        total++; if (state !== 3'd2) begin bad++; $display("FAIL to_reenter got=%0d want=2", state); end
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL to_reenter_tmo got=%0b want=0", tmo); end
        // Time CODE3 so that ST3 is taken on the same edge the timeout would fire
        for (int k = 1; k <= 15; k++) begin
            cyc((k <= 9) ? 2 : 4, 1'b1);
            total++; if (state !== 3'(m_state)) begin bad++; $display("FAIL race_state cyc=%0d got=%0d want=%0d", cyc_n, state, m_state); end
        end
        total++; if (state !== 3'd2) begin bad++; $display("FAIL race_pre got=%0d want=2", state); end
        cyc(4, 1'b1);
        total++; if (state !== 3'd3) begin bad++; $display("FAIL race_st3 got=%0d want=3", state); end
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL race_tmo got=%0b want=0", tmo); end
        total++; if (chg !== 1'b1) begin bad++; $display("FAIL race_chg got=%0b want=1", chg); end
    endtask

    task automatic test_enable();
        int n;
        int ntmo;
        int nbad_st;
        n = 0;
        while (state !== 3'd1 && n < 20) begin
            cyc(1, 1'b1);
            n++;
        end
        total++; if (state !== 3'd1) begin bad++; $display("FAIL en_enter_st1 got=%0d want=1", state); end
        ntmo = 0; nbad_st = 0;
        for (int k = 0; k < 30; k++) begin
            cyc(2, 1'b0);
            total++; if (led !== 3'(exp_led(en))) begin bad++; $display("FAIL en_led cyc=%0d got=%0d want=%0d", cyc_n, led, exp_led(en)); end
            total++; if (chg !== m_chg) begin bad++; $display("FAIL en_chg cyc=%0d got=%0b want=%0b", cyc_n, chg, m_chg); end
            if (tmo !== 1'b0) ntmo++;
            if (state !== 3'd1) nbad_st++;
        end
        total++; if (nbad_st != 0) begin bad++; $display("FAIL en_frozen cycles_not_st1=%0d want=0", nbad_st); end
        total++; if (ntmo != 0) begin bad++; $display("FAIL en_no_tmo got=%0d want=0", ntmo); end
        cyc(2, 1'b1);
        total++; if (state !== 3'd2) begin bad++; $display("FAIL en_rise got=%0d want=2", state); end
        total++; if (chg !== 1'b1) begin bad++; $display("FAIL en_rise_chg got=%0b want=1", chg); end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (state !== 3'd3 && n < 20) begin cyc(4, 1'b1); n++; end
        n = 0;
        while (state !== 3'd4 && n < 20) begin cyc(7, 1'b1); n++; end
        total++; if (state !== 3'd4) begin bad++; $display("FAIL mid_enter_st4 got=%0d want=4", state); end
        rst = 1'b0;
        #2;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL mid_async_state got=%0d want=0", state); end
        total++; if (led !== 3'd0) begin bad++; $display("FAIL mid_async_led got=%0d want=0", led); end
        rst = 1'b1;
        model_reset();
        n = 0;
        while (state !== 3'd1 && n < 20) begin
            cyc(1, 1'b1);
            n++;
            total++; if (state !== 3'(m_state)) begin bad++; $display("FAIL mid_state cyc=%0d got=%0d want=%0d", cyc_n, state, m_state); end
        end
        total++; if (n != 7) begin bad++; $display("FAIL mid_requalify got=%0d want=7", n); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 250; it++) begin
            int v;
            int hold;
            bit e;
            v = $urandom_range(0, 7);
            hold = $urandom_range(1, 12);
            e = ($urandom_range(0, 9) < 8);
            for (int k = 0; k < hold; k++) begin
                cyc(v, e);
                total++; if (state !== 3'(m_state)) begin bad++; $display("FAIL rnd_state cyc=%0d got=%0d want=%0d", cyc_n, state, m_state); end
                total++; if (led !== 3'(exp_led(en))) begin bad++; $display("FAIL rnd_led cyc=%0d got=%0d want=%0d", cyc_n, led, exp_led(en)); end
                total++; if (chg !== m_chg) begin bad++; $display("FAIL rnd_chg cyc=%0d got=%0b want=%0b", cyc_n, chg, m_chg); end
                total++; if (tmo !== m_tmo) begin bad++; $display("FAIL rnd_tmo cyc=%0d got=%0b want=%0b", cyc_n, tmo, m_tmo); end
            end
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc_n = 0;
        test_reset();
        test_walk();
        test_debounce();
        test_timeout();
        test_enable();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
